wr_dest_pipe: RTL and testbench

Carries the 5-bit destination-register number chosen by the EX-stage register-destination mux (rt/rd/31) through the EX/MEM and MEM/WB pipeline registers, together with its RegWrite qualifier. From the tracked destinations it generates the ALU operand forwarding selects and the load-use hazard stall. It sits directly downstream of the destination mux and drives the register-file write port and the ALU operand muxes.

---
 rtl/wr_dest_pipe.sv | 107 ++++++++++
 tb/tb_wr_dest_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wr_dest_pipe.sv
// wr_dest_pipe: carries the EX-stage destination register and its RegWrite
// qualifier through EX/MEM and MEM/WB, and derives the ALU operand forwarding
// selects and the load-use stall from the tracked destinations.
//
// Optional feature macro: WR_DEST_STALL_CNT_EN
//   defined   -> stall_count counts load-use stall cycles (saturating)
//   undefined -> stall_count is tied to zero and no counter flops exist
module wr_dest_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ex_wr_addr,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        pipe_hold,
    input  logic        mem_flush,
    output logic [4:0]  mem_wr_addr,
    output logic        mem_reg_write,
    output logic [4:0]  wb_wr_addr,
    output logic        wb_reg_write,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        load_use_stall,
    output logic [15:0] stall_count
);

    localparam int unsigned AW = 5;
    localparam int unsigned FW = 2;
    localparam int unsigned CW = 16;

    localparam logic [FW-1:0] FWD_RF  = 2'b00;
    localparam logic [FW-1:0] FWD_MEM = 2'b10;
    localparam logic [FW-1:0] FWD_WB  = 2'b01;

    logic mem_eff;
    logic wb_eff;
    logic ex_eff;

    // EX/MEM and MEM/WB destination registers; hold beats flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_addr   <= '0;
            mem_reg_write <= 1'b0;
            wb_wr_addr    <= '0;
            wb_reg_write  <= 1'b0;
        end else if (!pipe_hold) begin
            if (mem_flush) begin
                mem_wr_addr   <= '0;
                mem_reg_write <= 1'b0;
            end else begin
                mem_wr_addr   <= ex_wr_addr;
                mem_reg_write <= ex_reg_write;
            end
            wb_wr_addr   <= mem_wr_addr;
            wb_reg_write <= mem_reg_write;
        end
    end

    // Forwarding selects; $0 never forwards and the younger EX/MEM value wins
    always_comb begin
        mem_eff = mem_reg_write && (mem_wr_addr != AW'(0));
        wb_eff  = wb_reg_write  && (wb_wr_addr  != AW'(0));
        fwd_a   = FWD_RF;
        fwd_b   = FWD_RF;
        if (mem_eff && (mem_wr_addr == ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (wb_eff && (wb_wr_addr == ex_rs)) begin
            fwd_a = FWD_WB;
        end
        if (mem_eff && (mem_wr_addr == ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (wb_eff && (wb_wr_addr == ex_rt)) begin
            fwd_b = FWD_WB;
        end
    end

    // Load-use hazard: a load in EX targets a register the ID instruction reads
    always_comb begin
        ex_eff         = ex_reg_write && (ex_wr_addr != AW'(0));
        load_use_stall = ex_mem_read && ex_eff &&
                         ((id_uses_rs && (id_rs == ex_wr_addr)) ||
                          (id_uses_rt && (id_rt == ex_wr_addr)));
    end

`ifdef WR_DEST_STALL_CNT_EN
    logic [CW-1:0] stall_cnt_q;

    // Saturating count of stall cycles that actually advance the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (!pipe_hold && load_use_stall && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CW'(1);
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = CW'(0);
`endif

endmodule

// File: tb/tb_wr_dest_pipe.sv
// Testbench for wr_dest_pipe: directed vectors, a stage-history model and
// hand-computed literal expectations.
module tb_wr_dest_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ex_wr_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_rs, ex_rt, id_rs, id_rt;
    logic        id_uses_rs, id_uses_rt;
    logic        pipe_hold, mem_flush;
    logic [4:0]  mem_wr_addr, wb_wr_addr;
    logic        mem_reg_write, wb_reg_write;
    logic [1:0]  fwd_a, fwd_b;
    logic        load_use_stall;
    logic [15:0] stall_count;

    int compared   = 0;
    int mismatched = 0;

    wr_dest_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .ex_wr_addr(ex_wr_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .pipe_hold(pipe_hold), .mem_flush(mem_flush),
        .mem_wr_addr(mem_wr_addr), .mem_reg_write(mem_reg_write),
        .wb_wr_addr(wb_wr_addr), .wb_reg_write(wb_reg_write),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .load_use_stall(load_use_stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Model: stage[0] is EX/MEM, stage[1] is MEM/WB (younger first)
    int unsigned m_dst [2];
    bit          m_wr  [2];
    int unsigned m_cnt;

    function automatic bit eff(input bit wr, input int unsigned dst);
        return wr && dst != 0;
    endfunction

    // Age order search: the youngest effective writer of src wins
    function automatic int unsigned m_fwd(input int unsigned src);
        for (int s = 0; s < 2; s++)
            if (eff(m_wr[s], m_dst[s]) && m_dst[s] == src)
                return (s == 0) ? 2 : 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        return ex_mem_read && eff(ex_reg_write, ex_wr_addr) &&
               ((id_uses_rs && id_rs == ex_wr_addr) || (id_uses_rt && id_rt == ex_wr_addr));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dst = '{0, 0};
            m_wr  = '{0, 0};
            m_cnt = 0;
        end else if (!pipe_hold) begin
`ifdef WR_DEST_STALL_CNT_EN
            if (m_stall() && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
            m_dst[1] = m_dst[0];
            m_wr[1]  = m_wr[0];
            m_dst[0] = mem_flush ? 0 : int'(ex_wr_addr);
            m_wr[0]  = mem_flush ? 1'b0 : ex_reg_write;
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("m_mem_wr_addr",   int'(mem_wr_addr),    m_dst[0]);
        check("m_mem_reg_write", int'(mem_reg_write),  int'(m_wr[0]));
        check("m_wb_wr_addr",    int'(wb_wr_addr),     m_dst[1]);
        check("m_wb_reg_write",  int'(wb_reg_write),   int'(m_wr[1]));
        check("m_fwd_a",         int'(fwd_a),          m_fwd(int'(ex_rs)));
        check("m_fwd_b",         int'(fwd_b),          m_fwd(int'(ex_rt)));
        check("m_stall",         int'(load_use_stall), int'(m_stall()));
        check("m_stall_count",   int'(stall_count),    m_cnt);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ex(input logic [4:0] a, input logic w);
        ex_wr_addr   = a;
        ex_reg_write = w;
    endtask

    initial begin
        rst_n = 1'b0;
        set_ex(5'd0, 1'b0);
        ex_mem_read = 0; ex_rs = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
        id_uses_rs = 0; id_uses_rt = 0; pipe_hold = 0; mem_flush = 0;
        cyc(); cyc();
        check("rst_mem_wr_addr", int'(mem_wr_addr), 0);
        check("rst_fwd_a", int'(fwd_a), 0);
        rst_n = 1'b1;

        // Latency: 5 on mem after one edge, on wb after two
        set_ex(5'd5, 1'b1);
        cyc();
        check("lat_mem5", int'(mem_wr_addr), 5);
        check("lat_mem5_rw", int'(mem_reg_write), 1);
        set_ex(5'd0, 1'b0);
        cyc();
        check("lat_wb5", int'(wb_wr_addr), 5);

        // Reset mid-stream clears immediately
        set_ex(5'd7, 1'b1); cyc();
        set_ex(5'd3, 1'b1); cyc();
        ex_rs = 5'd3;
        #1 check("pre_rst_fwd_a", int'(fwd_a), 2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem", int'(mem_wr_addr), 0);
        check("rst_mid_wb", int'(wb_wr_addr), 0);
        check("rst_mid_wb_rw", int'(wb_reg_write), 0);
        check("rst_mid_fwd_a", int'(fwd_a), 0);
        set_ex(5'd0, 1'b0);
        ex_rs = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("restart_empty_wb", int'(wb_reg_write), 0);

        // Back-to-back dependency on $8
        set_ex(5'd8, 1'b1); ex_rs = 5'd8;
        cyc();
        check("fwd_a_exmem", int'(fwd_a), 2);
        set_ex(5'd0, 1'b0);
        cyc();
        check("fwd_a_memwb", int'(fwd_a), 1);
        set_ex(5'd8, 1'b1); cyc(); cyc();
        ex_rt = 5'd8;
        #1 check("fwd_b_both", int'(fwd_b), 2);

        // $0 filter
        set_ex(5'd0, 1'b1); cyc();
        ex_rs = 0; ex_rt = 0;
        #1 check("zero_fwd_a", int'(fwd_a), 0);
        ex_mem_read = 1; id_rs = 0; id_uses_rs = 1;
        #1 check("zero_stall", int'(load_use_stall), 0);

        // Load-use
        id_uses_rs = 0; set_ex(5'd9, 1'b1); id_rt = 5'd9; id_uses_rt = 1;
        #1 check("lu_stall", int'(load_use_stall), 1);
        id_uses_rt = 0;
        #1 check("lu_no_use", int'(load_use_stall), 0);
        ex_mem_read = 0;

        // Hold freezes stages
        set_ex(5'd10, 1'b1); cyc();
        set_ex(5'd14, 1'b1); cyc();
        pipe_hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'(11 + i), 1'b1);
            cyc();
            check("hold_mem", int'(mem_wr_addr), 14);
            check("hold_wb", int'(wb_wr_addr), 10);
        end
        pipe_hold = 0;

        // Flush inserts a bubble
        mem_flush = 1; set_ex(5'd15, 1'b1); cyc();
        check("flush_mem", int'(mem_wr_addr), 0);
        check("flush_mem_rw", int'(mem_reg_write), 0);
        check("flush_wb", int'(wb_wr_addr), 14);
        mem_flush = 0; set_ex(5'd16, 1'b1); cyc();
        pipe_hold = 1; mem_flush = 1; cyc();
        check("both_mem", int'(mem_wr_addr), 16);
        check("both_wb", int'(wb_wr_addr), 0);
        pipe_hold = 0; mem_flush = 0;

        // Three stall cycles, one under hold
        ex_mem_read = 1; set_ex(5'd9, 1'b1); id_rt = 5'd9; id_uses_rt = 1;
        cyc();
        pipe_hold = 1; cyc();
        pipe_hold = 0; cyc();
        ex_mem_read = 0;
`ifdef WR_DEST_STALL_CNT_EN
        check("cnt_two", int'(stall_count), 2);
        ex_mem_read = 1;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #2 check("cnt_sat", int'(stall_count), 65535);
        cyc();
        check("cnt_sat_hold", int'(stall_count), 65535);
        ex_mem_read = 0;
`else
        check("cnt_off", int'(stall_count), 0);
`endif
        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
